// File: rtl/corelet_pkg.sv
//------------------------------------------------------------------------------
// Package   : corelet_pkg
// Purpose   : Shared definitions for the corelet instruction sequencer:
//             instruction-word bit positions and fields, the idle value of the
//             instruction word, FSM state encoding, and a constant-evaluable
//             integer square root used to derive image widths from pixel
//             counts.
// Ports     : none (package)
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package corelet_pkg;

  // Instruction word layout
  localparam int INST_W            = 34;
  localparam int INST_MAC_LOAD     = 0;
  localparam int INST_MAC_EXEC     = 1;
  localparam int INST_L0_WR        = 2;
  localparam int INST_L0_RD        = 3;
  localparam int INST_OFIFO_RD     = 6;
  localparam int INST_PMEM_ADD_LSB = 7;
  localparam int INST_PMEM_ADD_MSB = 17;
  localparam int INST_PMEM_WEN_N   = 18;
  localparam int INST_PMEM_CEN_N   = 19;
  localparam int INST_XMEM_ADD_LSB = 20;
  localparam int INST_XMEM_ADD_MSB = 30;
  localparam int INST_XMEM_WEN_N   = 31;
  localparam int INST_XMEM_CEN_N   = 32;
  localparam int INST_ACC          = 33;

  // Both SRAMs deselected (cen_n/wen_n high), every strobe low:
  // bits 18, 19, 31 and 32 set.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  // FSM state encoding
  localparam int            ST_W     = 4;
  localparam logic [ST_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [ST_W-1:0] ST_K_L0  = 4'd1;
  localparam logic [ST_W-1:0] ST_K_ARR = 4'd2;
  localparam logic [ST_W-1:0] ST_A_L0  = 4'd3;
  localparam logic [ST_W-1:0] ST_EXEC  = 4'd4;
  localparam logic [ST_W-1:0] ST_WAIT  = 4'd5;
  localparam logic [ST_W-1:0] ST_DRAIN = 4'd6;
  localparam logic [ST_W-1:0] ST_ACC   = 4'd7;
  localparam logic [ST_W-1:0] ST_FIN   = 4'd8;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_K_L0  = ST_K_L0,
    S_K_ARR = ST_K_ARR,
    S_A_L0  = ST_A_L0,
    S_EXEC  = ST_EXEC,
    S_WAIT  = ST_WAIT,
    S_DRAIN = ST_DRAIN,
    S_ACC   = ST_ACC,
    S_FIN   = ST_FIN
  } state_t;

  // Floor square root; used only on parameters at elaboration.
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/corelet_ctrl_acc_addr_gen.sv
//------------------------------------------------------------------------------
// Module    : acc_addr_gen
// Purpose   : Combinational pmem address for the partial-sum accumulation
//             pass: output pixel o and kernel position k map to
//             k*NIJ + (o/OW + k/KW)*IW + (o%OW + k%KW), where IW and OW are
//             the input and output image widths and KW = IW-OW+1 is the kernel
//             width. Present only when CORELET_CTRL_ACC_EN is defined.
// Ports     : o_i    in  O_W     output pixel index
//             k_i    in  K_W     kernel position index
//             addr_o out ADDR_W  pmem read address
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifdef CORELET_CTRL_ACC_EN
module acc_addr_gen
  import corelet_pkg::*;
#(
  parameter int NIJ    = 36,
  parameter int ONIJ   = 16,
  parameter int ADDR_W = 11,
  parameter int O_W    = 4,
  parameter int K_W    = 4
) (
  input  logic [O_W-1:0]    o_i,
  input  logic [K_W-1:0]    k_i,
  output logic [ADDR_W-1:0] addr_o
);

  typedef logic [ADDR_W-1:0] addr_t;

  localparam int IW = isqrt(NIJ);
  localparam int OW = isqrt(ONIJ);
  localparam int KW = IW - OW + 1;

  always_comb begin
    addr_o = addr_t'(k_i) * addr_t'(NIJ)
           + (addr_t'(o_i / OW) + addr_t'(k_i / KW)) * addr_t'(IW)
           + addr_t'(o_i % OW) + addr_t'(k_i % KW);
  end

endmodule
`endif

`default_nettype wire

// File: rtl/corelet_ctrl.sv
//------------------------------------------------------------------------------
// Module    : corelet_ctrl
// Purpose   : Instruction sequencer for one 3x3-kernel convolution tile. Per
//             kernel position it loads kernel words to L0 and into the array,
//             streams activations, executes, flushes the array and drains the
//             OFIFO into pmem. Optional macro CORELET_CTRL_ACC_EN adds a final
//             pass that sums partial results from pmem through the SFP.
// Ports     : clk   in  1   clock
//             reset in  1   asynchronous active-low reset
//             start in  1   one-cycle pulse, starts a tile when idle
//             inst  out 34  corelet/SRAM instruction word (registered)
//             busy  out 1   tile in progress (registered)
//             done  out 1   one-cycle completion pulse (registered)
//             kij   out 4   current kernel position (registered)
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int                ROW      = 8,
  parameter int                COL      = 8,
  parameter int                ADDR_W   = 11,
  parameter int                KIJ      = 9,
  parameter int                NIJ      = 36,
  parameter int                ONIJ     = 16,
  parameter logic [ADDR_W-1:0] KBASE    = 11'd1024,
  parameter logic [ADDR_W-1:0] ACC_BASE = 11'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij
);

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Last phase-counter value of each state
  localparam cnt_t C_KL0_END   = cnt_t'(COL);
  localparam cnt_t C_KARR_END  = cnt_t'(COL - 1);
  localparam cnt_t C_AL0_END   = cnt_t'(NIJ);
  localparam cnt_t C_EXEC_END  = cnt_t'(NIJ - 1);
  localparam cnt_t C_WAIT_END  = cnt_t'(ROW + COL - 1);
  localparam cnt_t C_DRAIN_END = cnt_t'(NIJ);
  localparam cnt_t C_COL       = cnt_t'(COL);
  localparam cnt_t C_NIJ       = cnt_t'(NIJ);
  localparam logic [3:0] KIJ_LAST = 4'(KIJ - 1);

  // Elaboration-time sanity on the parameter set
  if (ADDR_W != 11) begin : g_chk_addr_w
    $error("corelet_ctrl: instruction word fields are 11 bits wide");
  end
  if (KIJ * NIJ > (1 << ADDR_W)) begin : g_chk_pmem_fit
    $error("corelet_ctrl: KIJ*NIJ partial sums do not fit in pmem");
  end
  if (ONIJ > NIJ || int'(ACC_BASE) + ONIJ > (1 << ADDR_W)) begin : g_chk_onij
    $error("corelet_ctrl: ONIJ/ACC_BASE out of range");
  end

  state_t            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [3:0]        kij_q, kij_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef CORELET_CTRL_ACC_EN
  localparam int   O_W       = (ONIJ > 1) ? $clog2(ONIJ) : 1;
  localparam cnt_t C_ACC_END = cnt_t'(KIJ + 1);
  localparam cnt_t C_KIJ     = cnt_t'(KIJ);
  localparam logic [O_W-1:0] O_LAST = O_W'(ONIJ - 1);

  logic [O_W-1:0]    o_q, o_d;
  logic [ADDR_W-1:0] acc_addr;

  acc_addr_gen #(
    .NIJ    (NIJ),
    .ONIJ   (ONIJ),
    .ADDR_W (ADDR_W),
    .O_W    (O_W),
    .K_W    (4)
  ) u_acc_addr_gen (
    .o_i    (o_d),
    .k_i    (cnt_d[3:0]),
    .addr_o (acc_addr)
  );
`endif

  // Next state. The phase counter restarts at zero on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    kij_d   = kij_q;
`ifdef CORELET_CTRL_ACC_EN
    o_d     = o_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_K_L0;
          kij_d   = '0;
        end
      end
      S_K_L0:  if (cnt_q == C_KL0_END)  begin state_d = S_K_ARR; cnt_d = '0; end
      S_K_ARR: if (cnt_q == C_KARR_END) begin state_d = S_A_L0;  cnt_d = '0; end
      S_A_L0:  if (cnt_q == C_AL0_END)  begin state_d = S_EXEC;  cnt_d = '0; end
      S_EXEC:  if (cnt_q == C_EXEC_END) begin state_d = S_WAIT;  cnt_d = '0; end
      S_WAIT:  if (cnt_q == C_WAIT_END) begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN: begin
        if (cnt_q == C_DRAIN_END) begin
          cnt_d = '0;
          if (kij_q != KIJ_LAST) begin
            state_d = S_K_L0;
            kij_d   = kij_q + 4'd1;
          end else begin
`ifdef CORELET_CTRL_ACC_EN
            state_d = S_ACC;
            o_d     = '0;
`else
            state_d = S_FIN;
`endif
          end
        end
      end
`ifdef CORELET_CTRL_ACC_EN
      // One output pixel per KIJ+2 cycles: KIJ reads, one write, one clear.
      S_ACC: begin
        if (cnt_q == C_ACC_END) begin
          cnt_d = '0;
          if (o_q == O_LAST) state_d = S_FIN;
          else               o_d     = o_q + 1'b1;
        end
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with
  // the state they describe. Reads issue on phase 0..N-1; the consumer strobe
  // follows on phase 1..N to cover the one-cycle SRAM read latency.
  always_comb begin
    inst_d = INST_IDLE;
    case (state_d)
      S_K_L0: begin
        if (cnt_d < C_COL) begin
          inst_d[INST_XMEM_CEN_N] = 1'b0;
          inst_d[INST_XMEM_ADD_MSB:INST_XMEM_ADD_LSB] =
            KBASE + addr_t'(kij_d) * addr_t'(COL) + addr_t'(cnt_d);
        end
        inst_d[INST_L0_WR] = (cnt_d != '0);
      end
      S_K_ARR: begin
        inst_d[INST_L0_RD]    = 1'b1;
        inst_d[INST_MAC_LOAD] = 1'b1;
      end
      S_A_L0: begin
        if (cnt_d < C_NIJ) begin
          inst_d[INST_XMEM_CEN_N] = 1'b0;
          inst_d[INST_XMEM_ADD_MSB:INST_XMEM_ADD_LSB] = addr_t'(cnt_d);
        end
        inst_d[INST_L0_WR] = (cnt_d != '0);
      end
      S_EXEC: begin
        inst_d[INST_L0_RD]    = 1'b1;
        inst_d[INST_MAC_EXEC] = 1'b1;
      end
      S_DRAIN: begin
        inst_d[INST_OFIFO_RD] = (cnt_d < C_NIJ);
        if (cnt_d != '0) begin
          inst_d[INST_PMEM_CEN_N] = 1'b0;
          inst_d[INST_PMEM_WEN_N] = 1'b0;
          inst_d[INST_PMEM_ADD_MSB:INST_PMEM_ADD_LSB] =
            addr_t'(kij_d) * addr_t'(NIJ) + addr_t'(cnt_d) - addr_t'(1);
        end
      end
`ifdef CORELET_CTRL_ACC_EN
      S_ACC: begin
        if (cnt_d < C_KIJ) begin
          inst_d[INST_PMEM_CEN_N] = 1'b0;
          inst_d[INST_PMEM_ADD_MSB:INST_PMEM_ADD_LSB] = acc_addr;
        end else if (cnt_d == C_KIJ) begin
          inst_d[INST_PMEM_CEN_N] = 1'b0;
          inst_d[INST_PMEM_WEN_N] = 1'b0;
          inst_d[INST_PMEM_ADD_MSB:INST_PMEM_ADD_LSB] = ACC_BASE + addr_t'(o_d);
        end
        inst_d[INST_ACC] = (cnt_d != '0) && (cnt_d <= C_KIJ);
      end
`endif
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CORELET_CTRL_ACC_EN
      o_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CORELET_CTRL_ACC_EN
      o_q     <= o_d;
`endif
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule

`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
//------------------------------------------------------------------------------
// Module    : tb_corelet_ctrl
// Purpose   : Directed self-checking bench for corelet_ctrl with hand-computed
//             expected values (reset state, kernel load, full tile write
//             sequence and done timing, start-while-busy, mid-tile reset, and
//             the accumulation pass when CORELET_CTRL_ACC_EN is defined).
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_corelet_ctrl;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  corelet_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .inst  (inst),
    .busy  (busy),
    .done  (done),
    .kij   (kij)
  );

  always #5 clk = ~clk;

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  // 9 kernel positions x (9+8+37+36+16+37) cycles, FIN one cycle later
`ifdef CORELET_CTRL_ACC_EN
  localparam int DONE_CYC = 1288 + 16 * 11;
  localparam int N_WR     = 324 + 16;
`else
  localparam int DONE_CYC = 1288;
  localparam int N_WR     = 324;
`endif
  localparam int MAX_CYC = DONE_CYC + 20;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One tile. Cycle c is the c-th falling edge after the start pulse.
  task automatic run_tile(input bit inj_start, input bit inj_reset);
    int   done_cnt = 0, done_cyc = 0, wr_cnt = 0, wr_err = 0;
    int   kl0_err = 0, l0wr_cnt = 0, karr_cnt = 0, busy_err = 0;
    int   kstep = 0, kij_err = 0;
    bit   pulsed = 1'b0;
    logic prev_ofifo = 1'b0;
    logic [3:0] last_kij = 4'd0;
`ifdef CORELET_CTRL_ACC_EN
    logic [10:0] acc_exp [9] = '{11'd7, 11'd44, 11'd81, 11'd121, 11'd158,
                                 11'd195, 11'd235, 11'd272, 11'd309};
    int   acc_err = 0, acc_hi = 0;
`endif
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= MAX_CYC; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        check("busy_first", busy, 1'b1);
        check("l0wr_c1", inst[2], 1'b0);
      end
      if (c <= 8 && (inst[32] !== 1'b0 || inst[31] !== 1'b1 ||
                     inst[30:20] !== 11'(1023 + c))) kl0_err++;
      if (c <= 9 && inst[2]) l0wr_cnt++;
      if (c <= 20 && inst[3:0] == 4'b1001) karr_cnt++;
      if (c < DONE_CYC && busy !== 1'b1) busy_err++;

      if (inj_reset && c == 350) begin
        check("exec_kij", kij, 4'd2);
        check("exec_strb", inst[3:0], 4'b1010);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_inst", inst, IDLE_WORD);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_kij", kij, 4'd0);
        reset = 1'b1;
        return;
      end

      if (inj_start) begin
        if (start) start = 1'b0;
        if (!pulsed && kij == 4'd4) begin
          start = 1'b1;
          pulsed = 1'b1;
          last_kij = 4'd4;
        end else if (pulsed && kij !== last_kij) begin
          if (kij !== last_kij + 4'd1) kij_err++;
          kstep++;
          last_kij = kij;
        end
      end

      if (inst[19] === 1'b0 && inst[18] === 1'b0) begin
        if (wr_cnt < 324 && (inst[17:7] !== wr_cnt[10:0] || prev_ofifo !== 1'b1))
          wr_err++;
        wr_cnt++;
      end
      prev_ofifo = inst[6];

`ifdef CORELET_CTRL_ACC_EN
      // Output pixel o=5 occupies ACC cycles 55..65
      if (c >= 1288 + 55 && c <= 1288 + 65) begin
        if (c <= 1288 + 63 && (inst[19] !== 1'b0 || inst[18] !== 1'b1 ||
                               inst[17:7] !== acc_exp[c - 1288 - 55])) acc_err++;
        if (inst[33]) acc_hi++;
        if (c == 1288 + 64) begin
          check("acc_wr_en", {inst[19], inst[18]}, 2'b00);
          check("acc_wr_add", inst[17:7], 11'd1029);
        end
      end
`endif

      if (done) begin
        done_cnt++;
        done_cyc = c;
        check("busy_at_done", busy, 1'b0);
        check("kij_at_done", kij, 4'd8);
      end
    end
    check("kl0_xmem_rd", kl0_err, 0);
    check("kl0_l0wr_cnt", l0wr_cnt, 8);
    check("karr_cycles", karr_cnt, 8);
    check("busy_span", busy_err, 0);
    check("pmem_wr_cnt", wr_cnt, N_WR);
    check("pmem_wr_seq", wr_err, 0);
    check("done_cnt", done_cnt, 1);
    check("done_cycle", done_cyc, DONE_CYC);
    check("idle_after", {busy, done}, 2'b00);
    if (inj_start) begin
      check("kij_steps", kstep, 4);
      check("kij_order", kij_err, 0);
      check("kij_last", last_kij, 4'd8);
    end
`ifdef CORELET_CTRL_ACC_EN
    check("acc_rd_add", acc_err, 0);
    check("acc_hi_cnt", acc_hi, 9);
`endif
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_inst", inst, IDLE_WORD);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_kij", kij, 4'd0);

    run_tile(1'b0, 1'b0);   // clean tile
    run_tile(1'b1, 1'b0);   // start pulse while busy at kij=4
    run_tile(1'b0, 1'b1);   // reset during EXEC of kij=2
    run_tile(1'b0, 1'b0);   // clean tile after reset

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
